// File: rtl/ps2_pkg.sv
// ps2_pkg: shared types and default timing for the PS/2 host transmitter.
//   ps2_tx_state_e  - transmitter FSM states
//   ps2_tx_status_e - tx_status result codes
//   PS2_*_CYC       - default timing constants at 100 MHz
//   ps2_max3        - helper used to size the shared timeout counter
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_REQ,
    ST_WAIT_CLK,
    ST_SEND,
    ST_ACK,
    ST_WAIT_IDLE,
    ST_FAIL
  } ps2_tx_state_e;

  typedef enum logic [1:0] {
    TX_ACK_OK   = 2'b00,
    TX_NACK     = 2'b01,
    TX_START_TO = 2'b10,
    TX_PKT_TO   = 2'b11
  } ps2_tx_status_e;

  localparam int unsigned PS2_INHIBIT_CYC  = 10000;    // 100 us
  localparam int unsigned PS2_START_TO_CYC = 1500000;  // 15 ms
  localparam int unsigned PS2_PKT_TO_CYC   = 200000;   // 2 ms

  function automatic int unsigned ps2_max3(input int unsigned a,
                                           input int unsigned b,
                                           input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// ps2_line_sync: two-flop synchronizer for one raw PS/2 line plus a
// falling-edge detect on the synchronized level.
//   clk, rstn - system clock, async active-low reset
//   pin       - raw line level (idle high)
//   level     - synchronized line level
//   fall      - one-cycle pulse when the synchronized level goes 1 -> 0
module ps2_line_sync (
  input  logic clk,
  input  logic rstn,
  input  logic pin,
  output logic level,
  output logic fall
);

  logic s1, s2, s3;

  // Flops reset to 1 so a bus that idles high never produces a false edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      s3 <= 1'b1;
    end else begin
      s1 <= pin;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign level = s2;
  assign fall  = s3 & ~s2;

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command transmitter (open-collector).
//   clk, rstn            - system clock, async active-low reset
//   tx_data, tx_valid    - command byte and send request
//   tx_ready             - high when idle; byte accepted on tx_valid && tx_ready
//   ps2_clk_in/data_in   - raw pin levels
//   ps2_clk_oe/data_oe   - 1 pulls the corresponding line low
//   rx_inhibit           - high whenever the transmitter is busy
//   tx_done, tx_status   - end-of-transaction pulse and result code
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYC  = PS2_INHIBIT_CYC,
  parameter int unsigned START_TO_CYC = PS2_START_TO_CYC,
  parameter int unsigned PKT_TO_CYC   = PS2_PKT_TO_CYC
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       rx_inhibit,
  output logic       tx_done,
  output logic [1:0] tx_status
);

  localparam int unsigned CW = $clog2(ps2_max3(INHIBIT_CYC, START_TO_CYC, PKT_TO_CYC));

  localparam logic [CW-1:0] INH_LAST   = CW'(INHIBIT_CYC - 1);
  localparam logic [CW-1:0] START_LAST = CW'(START_TO_CYC - 1);
  localparam logic [CW-1:0] PKT_LAST   = CW'(PKT_TO_CYC - 1);

  logic clk_lvl, clk_fall;
  logic data_lvl, data_fall_unused;

  ps2_line_sync u_clk_sync (
    .clk   (clk),
    .rstn  (rstn),
    .pin   (ps2_clk_in),
    .level (clk_lvl),
    .fall  (clk_fall)
  );

  // The ACK is taken from the data level at a clock fall; data edges are not used.
  ps2_line_sync u_data_sync (
    .clk   (clk),
    .rstn  (rstn),
    .pin   (ps2_data_in),
    .level (data_lvl),
    .fall  (data_fall_unused)
  );

  ps2_tx_state_e  state;
  ps2_tx_status_e status_q, res_q;
  logic [CW-1:0]  cnt, cnt_inc;
  logic [3:0]     n;
  logic [7:0]     sh;
  logic           par;
  logic           clk_oe_q, data_oe_q, done_q, ready_q, inhibit_q;

  // Saturating increment shared by every timing phase.
  assign cnt_inc = (&cnt) ? cnt : cnt + 1'b1;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= ST_IDLE;
      status_q  <= TX_ACK_OK;
      res_q     <= TX_ACK_OK;
      cnt       <= '0;
      n         <= '0;
      sh        <= '0;
      par       <= 1'b0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      done_q    <= 1'b0;
      ready_q   <= 1'b1;
      inhibit_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          ready_q <= 1'b1;
          if (tx_valid && ready_q) begin
            sh        <= tx_data;
            par       <= ~^tx_data;
            cnt       <= '0;
            n         <= '0;
            clk_oe_q  <= 1'b1;
            ready_q   <= 1'b0;
            inhibit_q <= 1'b1;
            state     <= ST_INHIBIT;
          end
        end

        ST_INHIBIT: begin
          if (cnt == INH_LAST) begin
            cnt       <= '0;
            data_oe_q <= 1'b1;
            state     <= ST_REQ;
          end else begin
            cnt <= cnt_inc;
          end
        end

        // Start bit is already on data; releasing clock hands control to the device.
        ST_REQ: begin
          clk_oe_q <= 1'b0;
          cnt      <= '0;
          state    <= ST_WAIT_CLK;
        end

        ST_WAIT_CLK: begin
          if (clk_fall) begin
            data_oe_q <= ~sh[0];
            n         <= 4'd1;
            cnt       <= '0;
            state     <= ST_SEND;
          end else if (cnt == START_LAST) begin
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            res_q     <= TX_START_TO;
            state     <= ST_FAIL;
          end else begin
            cnt <= cnt_inc;
          end
        end

        // One packet timer covers SEND, ACK and WAIT_IDLE and beats any fall.
        ST_SEND, ST_ACK, ST_WAIT_IDLE: begin
          if (cnt == PKT_LAST) begin
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            res_q     <= TX_PKT_TO;
            state     <= ST_FAIL;
          end else begin
            cnt <= cnt_inc;
            if (state == ST_SEND) begin
              if (clk_fall) begin
                if (n <= 4'd7) begin
                  data_oe_q <= ~sh[n[2:0]];
                end else if (n == 4'd8) begin
                  data_oe_q <= ~par;
                end else begin
                  data_oe_q <= 1'b0;
                  state     <= ST_ACK;
                end
                n <= n + 4'd1;
              end
            end else if (state == ST_ACK) begin
              if (clk_fall) begin
                res_q <= data_lvl ? TX_NACK : TX_ACK_OK;
                state <= ST_WAIT_IDLE;
              end
            end else if (clk_lvl && data_lvl) begin
              done_q    <= 1'b1;
              status_q  <= res_q;
              inhibit_q <= 1'b0;
              state     <= ST_IDLE;
            end
          end
        end

        ST_FAIL: begin
          done_q    <= 1'b1;
          status_q  <= res_q;
          inhibit_q <= 1'b0;
          state     <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;
  assign tx_done     = done_q;
  assign tx_status   = status_q;
  assign tx_ready    = ready_q;
  assign rx_inhibit  = inhibit_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
module tb_ps2_host_tx;

  localparam int unsigned INH  = 8;
  localparam int unsigned STO  = 50;
  localparam int unsigned PTO  = 400;
  localparam int          HALF = 10;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [7:0] tx_data = '0;
  logic       tx_valid = 1'b0;
  logic       tx_ready, ps2_clk_oe, ps2_data_oe, rx_inhibit, tx_done;
  logic [1:0] tx_status;
  logic       ps2_clk_in, ps2_data_in;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;

  int  checks = 0;
  int  errors = 0;
  time t_first_fall = 0;

  // Open-collector bus: either side pulling low wins.
  assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

  always #5 clk = ~clk;

  ps2_host_tx #(
    .INHIBIT_CYC  (INH),
    .START_TO_CYC (STO),
    .PKT_TO_CYC   (PTO)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .ps2_clk_in  (ps2_clk_in),
    .ps2_data_in (ps2_data_in),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe),
    .rx_inhibit  (rx_inhibit),
    .tx_done     (tx_done),
    .tx_status   (tx_status)
  );

  // rx_inhibit monitor: busy from the cycle after acceptance until tx_done.
  logic mon_en = 1'b0;
  logic acc = 1'b0;
  logic busy = 1'b0;
  int   rx_mism = 0;
  int   rx_hi = 0;
  always @(posedge clk) acc <= tx_valid && tx_ready;
  always @(negedge clk) begin
    if (mon_en) begin
      if (tx_done) busy = 1'b0;
      else if (acc) busy = 1'b1;
      if (rx_inhibit !== busy) rx_mism++;
      if (rx_inhibit === 1'b1) rx_hi++;
    end
  end

  function automatic logic [9:0] ref_frame(input logic [7:0] b);
    logic p;
    p = ($countones(b) % 2 == 0);
    return {1'b1, p, b};
  endfunction

  task automatic cyc(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic start_tx(input logic [7:0] b, output bit ok);
    int w;
    w = 0;
    while (tx_ready !== 1'b1 && w < 2000) begin cyc(1); w++; end
    ok = (tx_ready === 1'b1);
    tx_data  = b;
    tx_valid = 1'b1;
    cyc(1);
    tx_valid = 1'b0;
  endtask

  task automatic wait_req(output int inh);
    inh = 0;
    while (ps2_clk_oe === 1'b1 && ps2_data_oe === 1'b0 && inh < 1000) begin
      inh++;
      cyc(1);
    end
  endtask

  task automatic dev_frame(input int nfalls, input bit nack,
                           output logic [9:0] bits, output bit ok);
    int w;
    w = 0;
    bits = '0;
    while (!(ps2_clk_oe === 1'b0 && ps2_data_oe === 1'b1) && w < 3000) begin cyc(1); w++; end
    ok = (w < 3000);
    if (ok) begin
      cyc(5);
      for (int i = 0; i < nfalls; i++) begin
        if (i == 10 && !nack) dev_data_low = 1'b1;
        dev_clk_low = 1'b1;
        if (i == 0) t_first_fall = $time;
        cyc(HALF);
        dev_clk_low = 1'b0;
        if (i < 10) bits[i] = ps2_data_in;
        cyc(HALF);
        dev_data_low = 1'b0;
      end
    end
  endtask

  task automatic wait_done(output int k, output bit seen, output logic [1:0] st,
                           output logic [1:0] oe, output logic [1:0] after);
    k = 0;
    while (tx_done !== 1'b1 && k < 3000) begin cyc(1); k++; end
    seen  = (tx_done === 1'b1);
    st    = tx_status;
    oe    = {ps2_clk_oe, ps2_data_oe};
    cyc(1);
    after = {tx_done, tx_ready};
  endtask

  task automatic xfer(input logic [7:0] b, input bit nack, output bit ok,
                      output logic [9:0] bits, output logic [1:0] st,
                      output logic [1:0] after);
    bit a_ok, d_ok, seen;
    int k, inh;
    logic [1:0] oe;
    start_tx(b, a_ok);
    wait_req(inh);
    fork
      dev_frame(11, nack, bits, d_ok);
      wait_done(k, seen, st, oe, after);
    join
    ok = a_ok && d_ok && seen && (inh == INH) && (oe == 2'b00);
  endtask

  task automatic test_reset();
    logic [6:0] v;
    rstn = 1'b0;
    cyc(3);
    v = {ps2_clk_oe, ps2_data_oe, tx_done, tx_status, rx_inhibit, tx_ready};
    checks++;
    if (v !== 7'b0000001) begin
      errors++;
      $display("FAIL reset_outputs: got %b want 0000001", v);
    end
    rstn = 1'b1;
    cyc(3);
    v = {ps2_clk_oe, ps2_data_oe, tx_done, tx_status, rx_inhibit, tx_ready};
    checks++;
    if (v !== 7'b0000001) begin
      errors++;
      $display("FAIL idle_after_reset: got %b want 0000001", v);
    end
  endtask

  task automatic test_ack_ok();
    bit a_ok, d_ok, seen;
    int inh, k;
    logic [9:0] bits;
    logic [1:0] st, oe, after;
    start_tx(8'hED, a_ok);
    wait_req(inh);
    checks++;
    if (!a_ok || inh != INH) begin
      errors++;
      $display("FAIL ed_inhibit_len: got %0d cycles (accepted=%0d) want %0d", inh, a_ok, INH);
    end
    checks++;
    if ({ps2_clk_oe, ps2_data_oe} !== 2'b11) begin
      errors++;
      $display("FAIL ed_req: got oe=%b want 11", {ps2_clk_oe, ps2_data_oe});
    end
    fork
      dev_frame(11, 1'b0, bits, d_ok);
      wait_done(k, seen, st, oe, after);
    join
    checks++;
    if (!d_ok || bits !== ref_frame(8'hED)) begin
      errors++;
      $display("FAIL ed_bits: got %b want %b", bits, ref_frame(8'hED));
    end
    checks++;
    if (!seen || st !== 2'b00 || oe !== 2'b00) begin
      errors++;
      $display("FAIL ed_status: got done=%0d st=%b oe=%b want 1 00 00", seen, st, oe);
    end
    checks++;
    if (after !== 2'b01) begin
      errors++;
      $display("FAIL ed_after_done: got done,ready=%b want 01", after);
    end
  endtask

  task automatic test_nack();
    bit ok;
    logic [9:0] bits;
    logic [1:0] st, after;
    xfer(8'hFF, 1'b1, ok, bits, st, after);
    checks++;
    if (!ok || bits !== ref_frame(8'hFF) || bits[8] !== 1'b1) begin
      errors++;
      $display("FAIL ff_bits: got %b ok=%0d want %b", bits, ok, ref_frame(8'hFF));
    end
    checks++;
    if (st !== 2'b01) begin
      errors++;
      $display("FAIL ff_nack_status: got %b want 01", st);
    end
  endtask

  task automatic test_start_timeout();
    bit a_ok, seen;
    int inh, k;
    logic [1:0] st, oe, after;
    start_tx(8'h00, a_ok);
    wait_req(inh);
    wait_done(k, seen, st, oe, after);
    checks++;
    if (!a_ok || !seen || k < 48 || k > 56) begin
      errors++;
      $display("FAIL start_to_time: got %0d cycles (done=%0d) want ~%0d", k, seen, STO);
    end
    checks++;
    if (st !== 2'b10 || oe !== 2'b00) begin
      errors++;
      $display("FAIL start_to_status: got st=%b oe=%b want 10 00", st, oe);
    end
  endtask

  task automatic test_pkt_timeout();
    bit a_ok, d_ok, seen;
    int inh, k, dt;
    logic [9:0] bits;
    logic [1:0] st, oe, after;
    start_tx(8'hF4, a_ok);
    wait_req(inh);
    fork
      dev_frame(5, 1'b0, bits, d_ok);
      wait_done(k, seen, st, oe, after);
    join
    dt = int'(($time - t_first_fall) / 10) - 1;
    checks++;
    if (!a_ok || !d_ok || !seen || dt < 396 || dt > 410) begin
      errors++;
      $display("FAIL pkt_to_time: got %0d cycles after first fall (done=%0d) want ~%0d", dt, seen, PTO);
    end
    checks++;
    if (st !== 2'b11 || oe !== 2'b00 || ps2_clk_in !== 1'b1 || ps2_data_in !== 1'b1) begin
      errors++;
      $display("FAIL pkt_to_status: got st=%b oe=%b want 11 00 with lines high", st, oe);
    end
  endtask

  task automatic test_reset_mid_send();
    bit a_ok, d_ok, ok;
    int inh;
    logic [9:0] bits;
    logic [1:0] st, after;
    start_tx(8'hF4, a_ok);
    wait_req(inh);
    dev_frame(4, 1'b0, bits, d_ok);
    cyc(3);
    #2 rstn = 1'b0;
    #1;
    checks++;
    if ({ps2_clk_oe, ps2_data_oe, tx_ready, rx_inhibit} !== 4'b0010) begin
      errors++;
      $display("FAIL async_reset_release: got oe,ready,inh=%b want 0010",
               {ps2_clk_oe, ps2_data_oe, tx_ready, rx_inhibit});
    end
    @(negedge clk);
    cyc(2);
    rstn = 1'b1;
    cyc(2);
    checks++;
    if (tx_ready !== 1'b1 || !a_ok || !d_ok) begin
      errors++;
      $display("FAIL ready_after_reset: got %b want 1", tx_ready);
    end
    xfer(8'hF4, 1'b0, ok, bits, st, after);
    checks++;
    if (!ok || bits !== ref_frame(8'hF4) || st !== 2'b00) begin
      errors++;
      $display("FAIL f4_after_reset: got bits=%b st=%b want %b 00", bits, st, ref_frame(8'hF4));
    end
  endtask

  task automatic test_ignore_during_send();
    bit a_ok, d_ok, seen;
    logic rdy_seen;
    int inh, k;
    logic [9:0] bits;
    logic [1:0] st, oe, after;
    rx_mism = 0;
    rx_hi = 0;
    busy = 1'b0;
    mon_en = 1'b1;
    start_tx(8'h3C, a_ok);
    wait_req(inh);
    rdy_seen = 1'b1;
    fork
      dev_frame(11, 1'b0, bits, d_ok);
      wait_done(k, seen, st, oe, after);
      begin
        cyc(60);
        rdy_seen = tx_ready;
        tx_data  = 8'hA5;
        tx_valid = 1'b1;
        cyc(1);
        tx_valid = 1'b0;
      end
    join
    cyc(20);
    mon_en = 1'b0;
    checks++;
    if (!a_ok || !d_ok || rdy_seen !== 1'b0 || bits !== ref_frame(8'h3C) || st !== 2'b00) begin
      errors++;
      $display("FAIL ignore_valid: got bits=%b st=%b ready_mid=%b want %b 00 0",
               bits, st, rdy_seen, ref_frame(8'h3C));
    end
    checks++;
    if (ps2_clk_oe !== 1'b0 || tx_ready !== 1'b1) begin
      errors++;
      $display("FAIL no_second_frame: got clk_oe=%b ready=%b want 0 1", ps2_clk_oe, tx_ready);
    end
    checks++;
    if (rx_mism != 0 || rx_hi < int'(INH) + 200) begin
      errors++;
      $display("FAIL rx_inhibit_window: got %0d mismatched cycles, %0d high want 0, >=%0d",
               rx_mism, rx_hi, INH + 200);
    end
  endtask

  task automatic test_random();
    bit ok, nack;
    logic [7:0] b;
    logic [9:0] bits;
    logic [1:0] st, after;
    for (int i = 0; i < 5; i++) begin
      b    = 8'($urandom);
      nack = 1'($urandom_range(0, 1));
      xfer(b, nack, ok, bits, st, after);
      checks++;
      if (!ok || bits !== ref_frame(b) || st !== {1'b0, nack} || after !== 2'b01) begin
        errors++;
        $display("FAIL rand_%0d: byte=%h got bits=%b st=%b after=%b want %b 0%0d 01",
                 i, b, bits, st, after, ref_frame(b), nack);
      end
    end
  endtask

  initial begin
    test_reset();
    test_ack_ok();
    test_nack();
    test_start_timeout();
    test_pkt_timeout();
    test_reset_mid_send();
    test_ignore_during_send();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
